cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates up to NUM_REQ functional-unit result requesters onto the two common-data-bus ports (CDB1, CDB2) that the reservation stations and ROB snoop. Up to two results are granted per cycle under rotating round-robin priority. Granted results are broadcast from registered outputs for exactly one cycle. A flush suppresses grants and clears the bus.

## Interface
- NUM_REQ, 4, number of FU requesters (2..16)
- ROBEN_W, 5, ROB entry tag width; tag 0 = "no tag"
- DATA_W, 32, result width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- flush  in  1  ROB flush; drop all grants this cycle, clear bus next cycle
- req_valid  in  NUM_REQ  requester i has a result
- req_roben  in  NUM_REQ*ROBEN_W  tag of requester i, slice i
- req_val  in  NUM_REQ*DATA_W  result of requester i, slice i
- req_ready  out  NUM_REQ  combinational grant; handshake = valid & ready at posedge
- CDB_ROBEN1  out  ROBEN_W  port-1 tag, registered
- CDB_ROBEN1_VAL  out  DATA_W  port-1 value, registered
- CDB_ROBEN2  out  ROBEN_W  port-2 tag, registered
- CDB_ROBEN2_VAL  out  DATA_W  port-2 value, registered

## Operation
- State: priority pointer ptr (clog2(NUM_REQ) bits), plus the four registered CDB outputs.
- Eligible(i) = req_valid[i] & (req_roben slice i != 0).
- First pick: the first eligible index found scanning ptr, ptr+1, … mod NUM_REQ. Second pick: the next eligible index after the first pick in the same scan order.
- req_ready = 1 for both picks.
- req_ready = 1 also for any requester with valid=1 and tag 0. Such a request is drained with no broadcast and consumes no port.
- All other req_ready = 0.
- Next cycle: CDB_ROBEN1/VAL = first pick, CDB_ROBEN2/VAL = second pick. An unused port drives tag 0 and value 0.
- Pointer update on any grant: ptr <= (index of last real pick + 1) mod NUM_REQ. The last real pick is the second if present, otherwise the first. No real pick leaves ptr unchanged.
- flush=1 forces all req_ready to 0, clears all four CDB outputs next cycle, and holds ptr.
- Requesters hold valid, tag and value stable until they see ready. The arbiter does not latch non-granted requests.
- A duplicate tag from two requesters is a protocol error. Both may be granted; no checking is done.

## Timing
- Reset (rst=0 at posedge): CDB_ROBEN1=0, CDB_ROBEN1_VAL=0, CDB_ROBEN2=0, CDB_ROBEN2_VAL=0, ptr=0. req_ready is 0 while rst=0.
- Latency: a handshake at posedge t makes the data visible on the CDB during cycle t+1, for one cycle only. If there is no new grant, the outputs return to 0 at t+2.
- Throughput: 2 results/cycle. Any continuously valid requester waits at most ceil((NUM_REQ-1)/2) cycles before a grant.
- Wrap-around: ptr=NUM_REQ-1 with a grant at index NUM_REQ-1 sets ptr to 0.
- Reset mid-operation: pending requests are ignored that cycle, and the bus is cleared the next cycle.
- Simultaneous flush and reset: reset wins (same visible result).

## Structure
- Shared package cdb_pkg holds:
  - ROBEN_W and DATA_W defaults
  - NULL_ROBEN = 0
  - a typedef for the {roben, val} CDB beat, reused by the RS and ROB snoop logic
- Sub-module rr_pick: a purely combinational find-first-set starting from a base index over an eligibility mask. It outputs found and idx. It is instantiated twice:
  - first pick: base = ptr, mask = eligible
  - second pick: base = first idx + 1, mask = eligible with the first pick cleared

## Test plan
- Reset, then all valid, tags 1..4, values 0xA1..0xA4.
  - Cycle 1: ready=0011, CDB1=1/0xA1, CDB2=2/0xA2, ptr=2.
  - Cycle 2: ready=1100, CDB1=3, CDB2=4, ptr=0.
- Only requester 2 valid, tag 7, value 0x55: ready=0100. Next cycle CDB1=7/0x55, CDB2=0/0. The cycle after, both ports are 0.
- ptr=3 (via prior grant at 2), requesters 3 and 0 valid with tags 9 and 5: CDB1=9, CDB2=5 (wrap-around ordering), ptr becomes 1.
- Requesters 0 and 1 valid with flush=1: ready=0000, CDB ports 0 next cycle, ptr unchanged. Flush drops next cycle: both are granted normally.
- Requester 0 valid with tag 0, requesters 1 and 2 valid with tags 3 and 4: ready=0111, CDB1=3, CDB2=4, and nothing is broadcast for requester 0.
- Drive rst=0 for one cycle during a stream of grants: all CDB outputs are 0 and ptr=0 after that posedge. Arbitration resumes from requester 0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, the null tag, and the broadcast beat
// type that the arbiter, the reservation stations and the ROB snoop logic agree on.
package cdb_pkg;

   localparam int unsigned CDB_ROBEN_W = 5;
   localparam int unsigned CDB_DATA_W  = 32;

   // ROB tag 0 means "no tag"; nothing carrying it is ever broadcast
   localparam int unsigned NULL_ROBEN  = 0;

   typedef struct packed {
      logic [CDB_ROBEN_W-1:0] roben;
      logic [CDB_DATA_W-1:0]  val;
   } cdb_beat_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester / CDB bundle between the functional units and the CDB arbiter.
// The master side belongs to the FUs (and the flush source); the slave side
// belongs to the arbiter, which drives the grants and the two CDB ports.
interface cdb_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ROBEN_W = cdb_pkg::CDB_ROBEN_W,
   parameter int unsigned DATA_W  = cdb_pkg::CDB_DATA_W
);

   logic                       flush;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*ROBEN_W-1:0] req_roben;
   logic [NUM_REQ*DATA_W-1:0]  req_val;
   logic [NUM_REQ-1:0]         req_ready;
   logic [ROBEN_W-1:0]         CDB_ROBEN1;
   logic [DATA_W-1:0]          CDB_ROBEN1_VAL;
   logic [ROBEN_W-1:0]         CDB_ROBEN2;
   logic [DATA_W-1:0]          CDB_ROBEN2_VAL;

   modport master (
      output flush, req_valid, req_roben, req_val,
      input  req_ready, CDB_ROBEN1, CDB_ROBEN1_VAL, CDB_ROBEN2, CDB_ROBEN2_VAL
   );

   modport slave (
      input  flush, req_valid, req_roben, req_val,
      output req_ready, CDB_ROBEN1, CDB_ROBEN1_VAL, CDB_ROBEN2, CDB_ROBEN2_VAL
   );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational find-first-set over a mask, scanning base, base+1, ... mod N.
module rr_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] base,
   output logic         found,
   output logic [W-1:0] idx
);

   // Walk the mask in rotated order and keep the first set position
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         int unsigned j;
         j = (32'(base) + k) % N;
         if (!found && mask[j]) begin
            found = 1'b1;
            idx   = W'(j);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-port common-data-bus arbiter: grants up to two FU results per cycle
// under rotating priority and broadcasts them from registers for one cycle.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ROBEN_W = CDB_ROBEN_W,
   parameter int unsigned DATA_W  = CDB_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   cdb_arbiter_if.slave  bus
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ptr_nx;
   logic [PW-1:0]      base2;
   logic [PW-1:0]      idx1;
   logic [PW-1:0]      idx2;
   logic [PW-1:0]      last;
   logic [PW:0]        last_inc;
   logic               found1;
   logic               found2;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] zero_tag;
   logic [NUM_REQ-1:0] mask2;
   logic [NUM_REQ-1:0] grant;
   logic [ROBEN_W-1:0] tag_of [NUM_REQ];
   logic [DATA_W-1:0]  val_of [NUM_REQ];

   // Unpack the requester slices and classify each one
   always_comb begin
      elig     = '0;
      zero_tag = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         tag_of[i]   = bus.req_roben[i*ROBEN_W +: ROBEN_W];
         val_of[i]   = bus.req_val[i*DATA_W +: DATA_W];
         elig[i]     = bus.req_valid[i] && (tag_of[i] != ROBEN_W'(NULL_ROBEN));
         zero_tag[i] = bus.req_valid[i] && (tag_of[i] == ROBEN_W'(NULL_ROBEN));
      end
   end

   rr_pick #(.N(NUM_REQ), .W(PW)) u_pick1 (
      .mask  (elig),
      .base  (ptr),
      .found (found1),
      .idx   (idx1)
   );

   // Second scan starts just past the first pick; everything between ptr and
   // the first pick is already known ineligible, so the wrap cannot re-find it.
   always_comb begin
      base2 = idx1 + 1'b1;
      mask2 = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         mask2[i] = elig[i] && (PW'(i) != idx1);
      end
   end

   rr_pick #(.N(NUM_REQ), .W(PW)) u_pick2 (
      .mask  (mask2),
      .base  (base2),
      .found (found2),
      .idx   (idx2)
   );

   // Grants: both picks plus any tag-0 request, which is drained silently
   always_comb begin
      grant = '0;
      if (rst && !bus.flush) begin
         grant = zero_tag;
         if (found1) grant[idx1] = 1'b1;
         if (found2) grant[idx2] = 1'b1;
      end
      bus.req_ready = grant;
   end

   // Priority moves to just after the last real pick, wrapping at NUM_REQ
   always_comb begin
      last     = found2 ? idx2 : idx1;
      last_inc = {1'b0, last} + 1'b1;
      ptr_nx   = (last_inc == (PW+1)'(NUM_REQ)) ? '0 : last_inc[PW-1:0];
   end

   // Pointer and registered CDB ports; reset beats flush, flush blanks the bus
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr                <= '0;
         bus.CDB_ROBEN1     <= '0;
         bus.CDB_ROBEN1_VAL <= '0;
         bus.CDB_ROBEN2     <= '0;
         bus.CDB_ROBEN2_VAL <= '0;
      end else if (bus.flush) begin
         bus.CDB_ROBEN1     <= '0;
         bus.CDB_ROBEN1_VAL <= '0;
         bus.CDB_ROBEN2     <= '0;
         bus.CDB_ROBEN2_VAL <= '0;
      end else begin
         if (found1) ptr <= ptr_nx;
         bus.CDB_ROBEN1     <= found1 ? tag_of[idx1] : '0;
         bus.CDB_ROBEN1_VAL <= found1 ? val_of[idx1] : '0;
         bus.CDB_ROBEN2     <= found2 ? tag_of[idx2] : '0;
         bus.CDB_ROBEN2_VAL <= found2 ? val_of[idx2] : '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized requesters,
// with a reference model feeding a scoreboard queue that a monitor drains.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned RW = CDB_ROBEN_W;
   localparam int unsigned DW = CDB_DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b0;

   cdb_arbiter_if #(.NUM_REQ(N), .ROBEN_W(RW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_REQ(N), .ROBEN_W(RW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] t1;
      logic [DW-1:0] v1;
      logic [RW-1:0] t2;
      logic [DW-1:0] v2;
   } exp_t;

   exp_t        expq[$];
   int unsigned total = 0;
   int unsigned bad   = 0;
   bit          mon_en = 1'b0;
   int unsigned ptr_m  = 0;

   // requester-side model state: what each FU currently presents
   logic          m_valid [N];
   logic [RW-1:0] m_tag   [N];
   logic [DW-1:0] m_val   [N];
   logic [N-1:0]  last_ready;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // One cycle: drive inputs at negedge, predict grants and next-cycle bus
   task automatic step(input logic fl, input logic r);
      int   picks[$];
      exp_t e;
      logic [N-1:0] er;
      @(negedge clk);
      rst       = r;
      bus.flush = fl;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]              = m_valid[i];
         bus.req_roben[i*RW +: RW]     = m_tag[i];
         bus.req_val[i*DW +: DW]       = m_val[i];
      end
      #1;
      e  = '{t1: '0, v1: '0, t2: '0, v2: '0};
      er = '0;
      if (r && !fl) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr_m) + k) % N;
            if (m_valid[j] && m_tag[j] == 0) er[j] = 1'b1;
            if (m_valid[j] && m_tag[j] != 0 && picks.size() < 2) picks.push_back(j);
         end
         foreach (picks[p]) er[picks[p]] = 1'b1;
         if (picks.size() >= 1) begin
            e.t1 = m_tag[picks[0]];
            e.v1 = m_val[picks[0]];
         end
         if (picks.size() >= 2) begin
            e.t2 = m_tag[picks[1]];
            e.v2 = m_val[picks[1]];
         end
         if (picks.size() > 0) ptr_m = (picks[picks.size()-1] + 1) % N;
      end else if (!r) begin
         ptr_m = 0;
      end
      check("req_ready", 64'(bus.req_ready), 64'(er));
      last_ready = er;
      expq.push_back(e);
      mon_en = 1'b1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_val[i]   = '0;
      end
   endtask

   task automatic set_req(input int i, input logic [RW-1:0] t, input logic [DW-1:0] v);
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_val[i]   = v;
   endtask

   // Random FUs: idle ones may raise a new result; granted ones drop it
   task automatic rand_cycle(input logic fl, input logic r);
      for (int i = 0; i < N; i++) begin
         if (!m_valid[i] && ($urandom % 2 == 0)) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = ($urandom % 5 == 0) ? '0 : RW'($urandom_range(1, (1 << RW) - 1));
            m_val[i]   = DW'($urandom);
         end
      end
      step(fl, r);
      for (int i = 0; i < N; i++) if (last_ready[i]) m_valid[i] = 1'b0;
   endtask

   // Monitor: one scoreboard entry per cycle, compared just after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty: got no expectation want one (t=%0t)", $time);
            end else begin
               exp_t e;
               e = expq.pop_front();
               check("CDB_ROBEN1",     64'(bus.CDB_ROBEN1),     64'(e.t1));
               check("CDB_ROBEN1_VAL", 64'(bus.CDB_ROBEN1_VAL), 64'(e.v1));
               check("CDB_ROBEN2",     64'(bus.CDB_ROBEN2),     64'(e.t2));
               check("CDB_ROBEN2_VAL", 64'(bus.CDB_ROBEN2_VAL), 64'(e.v2));
            end
         end
      end
   end

   initial begin
      bus.flush     = 1'b0;
      bus.req_valid = '0;
      bus.req_roben = '0;
      bus.req_val   = '0;
      clear_all();

      // reset with idle requesters, then with requesters present (still no ready)
      step(1'b0, 1'b0);
      for (int i = 0; i < N; i++) set_req(i, RW'(i + 1), DW'(8'hA1 + i));
      step(1'b0, 1'b0);

      // all four valid: 0,1 first then 2,3
      step(1'b0, 1'b1);
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      step(1'b0, 1'b1);

      // single requester 2, then the bus returns to zero
      clear_all();
      set_req(2, RW'(7), DW'(32'h55));
      step(1'b0, 1'b1);
      clear_all();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // ptr is 3 now: 3 then 0 in wrap-around order
      set_req(3, RW'(9), DW'(32'h99));
      set_req(0, RW'(5), DW'(32'h50));
      step(1'b0, 1'b1);
      clear_all();

      // flush blocks grants, then they go through
      set_req(0, RW'(11), DW'(32'hB0));
      set_req(1, RW'(12), DW'(32'hB1));
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      clear_all();

      // tag-0 requester drained alongside two real picks
      set_req(0, RW'(0), DW'(32'hDEAD));
      set_req(1, RW'(3), DW'(32'h33));
      set_req(2, RW'(4), DW'(32'h44));
      step(1'b0, 1'b1);
      clear_all();

      // reset in the middle of a stream of grants
      for (int c = 0; c < 6; c++) rand_cycle(1'b0, (c == 3) ? 1'b0 : 1'b1);

      // randomized traffic with occasional flush and reset
      for (int c = 0; c < 400; c++)
         rand_cycle(($urandom % 8) == 0, ($urandom % 32) != 0);

      clear_all();
      step(1'b0, 1'b1);
      @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
